// File: rtl/mem_port_arbiter_if.sv
// Shared-memory port bundle: CPU requester, debug/loader requester,
// and the single InstAndDataMemory port behind the arbiter.
//
// Signals
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, held until cpu_ack
//   cpu_rdata/cpu_ack/cpu_stall        CPU read data, done pulse, stall
//   dbg_req/dbg_we/dbg_addr/dbg_wdata  debug request, held until dbg_ack
//   dbg_rdata/dbg_ack                  debug read data, done pulse
//   mem_addr/mem_wdata/mem_read/
//   mem_write/mem_rdata                memory port (rdata same-cycle)
//
// Modports
//   slave  : the arbiter
//   master : the surrounding requesters and memory
interface mem_port_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_stall;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    logic        dbg_ack;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU and a
// debug/loader requester.  IDLE -> BUSY (ACCESS_CYCLES) -> DONE.
//
// Ports
//   clk   : system clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : mem_port_arbiter_if.slave (requesters + memory port)
//
// Parameter
//   ACCESS_CYCLES : BUSY cycles per access, 1..4
module mem_port_arbiter #(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(ACCESS_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [1:0]  cnt_nxt;

    logic        last_cpu;
    logic        gnt_dbg;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] cpu_rdata_q;
    logic [31:0] dbg_rdata_q;

    logic        pick_dbg;
    logic        grab;
    logic        capture;
    logic        mem_read_c;
    logic        mem_write_c;
    logic        cpu_ack_c;
    logic        dbg_ack_c;

    // Debug wins when alone, or when contested and CPU went last.
    // last_cpu resets low so the first contested grant goes to CPU.
    always_comb begin
        pick_dbg = bus.dbg_req & (~bus.cpu_req | last_cpu);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        grab        = 1'b0;
        capture     = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        cpu_ack_c   = 1'b0;
        dbg_ack_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.cpu_req | bus.dbg_req) begin
                    grab      = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_read_c  = ~lat_we;
                // counter still at its load value only in BUSY cycle one
                mem_write_c = lat_we & (cnt == CNT_INIT);
                if (cnt == 2'd0) begin
                    capture   = ~lat_we;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            DONE: begin
                cpu_ack_c = ~gnt_dbg;
                dbg_ack_c = gnt_dbg;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_cpu    <= 1'b0;
            gnt_dbg     <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (grab) begin
                gnt_dbg  <= pick_dbg;
                last_cpu <= ~pick_dbg;
                unique case (1'b1)
                    pick_dbg: begin
                        lat_we    <= bus.dbg_we;
                        lat_addr  <= bus.dbg_addr;
                        lat_wdata <= bus.dbg_wdata;
                    end
                    default: begin
                        lat_we    <= bus.cpu_we;
                        lat_addr  <= bus.cpu_addr;
                        lat_wdata <= bus.cpu_wdata;
                    end
                endcase
            end
            if (capture) begin
                if (gnt_dbg) begin
                    dbg_rdata_q <= bus.mem_rdata;
                end else begin
                    cpu_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.mem_read  = mem_read_c;
    assign bus.mem_write = mem_write_c;
    assign bus.cpu_ack   = cpu_ack_c;
    assign bus.dbg_ack   = dbg_ack_c;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_c;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: instance 0 has ACCESS_CYCLES=1,
// instance 1 has ACCESS_CYCLES=3, each with its own small memory.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic        mem_load;
    logic        c_req   [2];
    logic        c_we    [2];
    logic [31:0] c_addr  [2];
    logic [31:0] c_wd    [2];
    logic        d_req   [2];
    logic        d_we    [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wd    [2];
    logic [31:0] c_rd    [2];
    logic [31:0] d_rd    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wd    [2];
    logic        c_ack   [2];
    logic        c_stall [2];
    logic        d_ack   [2];
    logic        m_read  [2];
    logic        m_write [2];
    logic [31:0] mem     [2][16];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    function automatic logic [31:0] pat(int g, int i);
        if (i == 4) return 32'h1234ABCD;
        return 32'hA5000000 | 32'(g << 8) | 32'(i);
    endfunction

    function automatic int acs(int g);
        return (g == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter_if bus ();
        assign bus.cpu_req   = c_req[g];
        assign bus.cpu_we    = c_we[g];
        assign bus.cpu_addr  = c_addr[g];
        assign bus.cpu_wdata = c_wd[g];
        assign bus.dbg_req   = d_req[g];
        assign bus.dbg_we    = d_we[g];
        assign bus.dbg_addr  = d_addr[g];
        assign bus.dbg_wdata = d_wd[g];
        assign bus.mem_rdata = mem[g][bus.mem_addr[5:2]];
        assign c_rd[g]    = bus.cpu_rdata;
        assign c_ack[g]   = bus.cpu_ack;
        assign c_stall[g] = bus.cpu_stall;
        assign d_rd[g]    = bus.dbg_rdata;
        assign d_ack[g]   = bus.dbg_ack;
        assign m_addr[g]  = bus.mem_addr;
        assign m_wd[g]    = bus.mem_wdata;
        assign m_read[g]  = bus.mem_read;
        assign m_write[g] = bus.mem_write;
        mem_port_arbiter #(.ACCESS_CYCLES(g == 0 ? 1 : 3)) dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (bus)
        );
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 16; i++) begin
                if (mem_load) begin
                    mem[g][i] <= pat(g, i);
                end else if (m_write[g] && m_addr[g][5:2] == 4'(i)) begin
                    mem[g][i] <= m_wd[g];
                end
            end
        end
    end

    task automatic check1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] act,
                           input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs(input int g);
        c_req[g] = 1'b0; c_we[g] = 1'b0; c_addr[g] = '0; c_wd[g] = '0;
        d_req[g] = 1'b0; d_we[g] = 1'b0; d_addr[g] = '0; d_wd[g] = '0;
    endtask

    typedef struct {
        int          g;
        bit          cr, cw;
        logic [31:0] ca, cwd;
        bit          dr, dw;
        logic [31:0] da, dwd;
        bit          rd, wr;
        logic [31:0] ma;
        bit          cack, dack, st;
        logic [31:0] crd, drd;
    } vec_t;

    task automatic run_random(input int g, input int n);
        int          ac;
        bit          rq [2];
        bit          rwe [2];
        int          ridx [2];
        logic [31:0] rwd [2];
        logic [31:0] mm [16];
        logic [31:0] erd [2];
        int          who, gs, gidx, free_at;
        bit          gwe, last_cpu, busy, ackn;
        logic [31:0] gwd;
        ac = acs(g);
        idle_inputs(g);
        mem_load = 1'b1;
        rst[g] = 1'b1;
        step();
        mem_load = 1'b0;
        rst[g] = 1'b0;
        for (int i = 0; i < 16; i++) mm[i] = pat(g, i);
        for (int r = 0; r < 2; r++) begin
            rq[r] = 0; rwe[r] = 0; ridx[r] = 0; rwd[r] = '0; erd[r] = '0;
        end
        who = -1; gs = 0; gidx = 0; gwe = 0; gwd = '0;
        last_cpu = 0;
        free_at = cyc;
        for (int k = 0; k < n; k++) begin
            busy = (who >= 0) && cyc >= gs && cyc < gs + ac;
            ackn = (who >= 0) && cyc == gs + ac;
            if (ackn && !gwe) erd[who] = mm[gidx];
            check1("rnd mem_read", m_read[g], busy && !gwe);
            check1("rnd mem_write", m_write[g], busy && gwe && cyc == gs);
            if (busy) check32("rnd mem_addr", m_addr[g], 32'(gidx) << 2);
            if (busy && gwe) check32("rnd mem_wdata", m_wd[g], gwd);
            check1("rnd cpu_ack", c_ack[g], ackn && who == 0);
            check1("rnd dbg_ack", d_ack[g], ackn && who == 1);
            check32("rnd cpu_rdata", c_rd[g], erd[0]);
            check32("rnd dbg_rdata", d_rd[g], erd[1]);
            check1("rnd cpu_stall", c_stall[g],
                   c_req[g] && !(ackn && who == 0));
            for (int r = 0; r < 2; r++) begin
                if (ackn && who == r) begin
                    rq[r] = 0;
                end else if (!rq[r] && $urandom_range(0, 2) == 0) begin
                    rq[r]   = 1;
                    rwe[r]  = 1'($urandom_range(0, 1));
                    ridx[r] = int'($urandom_range(0, 15));
                    rwd[r]  = $urandom;
                end
            end
            c_req[g]  = rq[0];
            c_we[g]   = rwe[0];
            c_addr[g] = rq[0] ? 32'(ridx[0]) << 2 : $urandom;
            c_wd[g]   = rwd[0];
            d_req[g]  = rq[1];
            d_we[g]   = rwe[1];
            d_addr[g] = rq[1] ? 32'(ridx[1]) << 2 : $urandom;
            d_wd[g]   = rwd[1];
            if (cyc >= free_at && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) who = last_cpu ? 1 : 0;
                else who = rq[0] ? 0 : 1;
                last_cpu = (who == 0);
                gs   = cyc + 1;
                gwe  = rwe[who];
                gidx = ridx[who];
                gwd  = rwd[who];
                free_at = cyc + ac + 2;
                if (gwe) mm[gidx] = gwd;
            end
            step();
        end
        idle_inputs(g);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   ord[$];
        int   acks[$];
        int   cnt_a, cnt_b, overlap, idle_n;

        mem_load = 1'b1;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1;
            idle_inputs(g);
        end
        step();
        step();
        for (int g = 0; g < 2; g++) begin
            check1("rst mem_read", m_read[g], 1'b0);
            check1("rst mem_write", m_write[g], 1'b0);
            check1("rst cpu_ack", c_ack[g], 1'b0);
            check1("rst dbg_ack", d_ack[g], 1'b0);
            check1("rst cpu_stall", c_stall[g], 1'b0);
            check32("rst cpu_rdata", c_rd[g], '0);
            check32("rst dbg_rdata", d_rd[g], '0);
            check32("rst mem_addr", m_addr[g], '0);
            check32("rst mem_wdata", m_wd[g], '0);
        end
        mem_load = 1'b0;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // single CPU read, ACCESS_CYCLES=1
        tbl.push_back('{0, 1,0,32'h10,0, 0,0,0,0, 1,0,32'h10,
                        0,0,1, 0,0});
        tbl.push_back('{0, 1,0,32'h10,0, 0,0,0,0, 0,0,32'h10,
                        1,0,0, 32'h1234ABCD,0});
        tbl.push_back('{0, 0,0,32'h10,0, 0,0,0,0, 0,0,32'h10,
                        0,0,0, 32'h1234ABCD,0});
        // debug write, ACCESS_CYCLES=3
        tbl.push_back('{1, 0,0,0,0, 1,1,32'h40,32'hDEADBEEF, 0,1,32'h40,
                        0,0,0, 0,0});
        tbl.push_back('{1, 0,0,0,0, 1,1,32'h40,32'hDEADBEEF, 0,0,32'h40,
                        0,0,0, 0,0});
        tbl.push_back('{1, 0,0,0,0, 1,1,32'h40,32'hDEADBEEF, 0,0,32'h40,
                        0,0,0, 0,0});
        tbl.push_back('{1, 0,0,0,0, 1,1,32'h40,32'hDEADBEEF, 0,0,32'h40,
                        0,1,0, 0,0});
        tbl.push_back('{1, 0,0,0,0, 0,0,32'h40,32'hDEADBEEF, 0,0,32'h40,
                        0,0,0, 0,0});
        // addr and we change mid-access are ignored
        tbl.push_back('{1, 1,0,32'h10,0, 0,0,0,0, 1,0,32'h10,
                        0,0,1, 0,0});
        tbl.push_back('{1, 1,1,32'h20,32'hFFFF, 0,0,0,0, 1,0,32'h10,
                        0,0,1, 0,0});
        tbl.push_back('{1, 1,1,32'h20,32'hFFFF, 0,0,0,0, 1,0,32'h10,
                        0,0,1, 0,0});
        tbl.push_back('{1, 1,1,32'h20,32'hFFFF, 0,0,0,0, 0,0,32'h10,
                        1,0,0, 32'h1234ABCD,0});
        tbl.push_back('{1, 0,0,32'h20,0, 0,0,0,0, 0,0,32'h10,
                        0,0,0, 32'h1234ABCD,0});

        foreach (tbl[i]) begin
            v = tbl[i];
            c_req[v.g] = v.cr;  c_we[v.g] = v.cw;
            c_addr[v.g] = v.ca; c_wd[v.g] = v.cwd;
            d_req[v.g] = v.dr;  d_we[v.g] = v.dw;
            d_addr[v.g] = v.da; d_wd[v.g] = v.dwd;
            step();
            check1($sformatf("vec%0d mem_read", i), m_read[v.g], v.rd);
            check1($sformatf("vec%0d mem_write", i), m_write[v.g], v.wr);
            check32($sformatf("vec%0d mem_addr", i), m_addr[v.g], v.ma);
            check1($sformatf("vec%0d cpu_ack", i), c_ack[v.g], v.cack);
            check1($sformatf("vec%0d dbg_ack", i), d_ack[v.g], v.dack);
            check1($sformatf("vec%0d cpu_stall", i), c_stall[v.g], v.st);
            check32($sformatf("vec%0d cpu_rdata", i), c_rd[v.g], v.crd);
            check32($sformatf("vec%0d dbg_rdata", i), d_rd[v.g], v.drd);
        end

        // reset in the second BUSY cycle aborts the access
        c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 32'h10;
        step();
        check1("abort busy1 mem_read", m_read[1], 1'b1);
        step();
        check1("abort busy2 mem_read", m_read[1], 1'b1);
        rst[1] = 1'b1;
        step();
        check1("abort mem_read", m_read[1], 1'b0);
        check1("abort cpu_ack", c_ack[1], 1'b0);
        check32("abort cpu_rdata", c_rd[1], '0);
        check32("abort mem_addr", m_addr[1], '0);
        rst[1] = 1'b0;
        c_req[1] = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (c_ack[1] || d_ack[1]) cnt_a++;
        end
        check32("abort no ack", 32'(cnt_a), 32'd0);

        // withdrawn debug request gets no access
        c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h18;
        step();
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h1C;
        step();
        check1("withdraw cpu_ack", c_ack[0], 1'b1);
        check32("withdraw cpu_rdata", c_rd[0], pat(0, 6));
        c_req[0] = 1'b0;
        d_req[0] = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (m_read[0]) cnt_a++;
            if (d_ack[0]) cnt_b++;
        end
        check32("withdraw reads", 32'(cnt_a), 32'd0);
        check32("withdraw dbg_ack", 32'(cnt_b), 32'd0);

        // contention from reset release alternates CPU, DBG
        c_req[0] = 1'b1; c_addr[0] = 32'h10;
        d_req[0] = 1'b1; d_addr[0] = 32'h08;
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        overlap = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (c_ack[0] && d_ack[0]) overlap++;
            if (c_ack[0]) ord.push_back(0);
            if (d_ack[0]) ord.push_back(1);
        end
        idle_inputs(0);
        for (int k = 0; k < 4; k++) begin
            check32($sformatf("contend grant%0d", k),
                    (k < ord.size()) ? 32'(ord[k]) : 32'hFFFF_FFFF,
                    32'(k % 2));
        end
        check32("contend overlap", 32'(overlap), 32'd0);
        check32("contend dbg_rdata", d_rd[0], pat(0, 2));
        step();
        step();

        // back-to-back CPU reads with req held, ACCESS_CYCLES=3
        c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 32'h14;
        idle_n = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (c_ack[1]) acks.push_back(cyc);
            else if (acks.size() == 1 && !m_read[1]) idle_n++;
        end
        idle_inputs(1);
        for (int k = 0; k < 2; k++) begin
            check32($sformatf("b2b gap%0d", k),
                    (acks.size() > k + 1) ?
                        32'(acks[k + 1] - acks[k]) : 32'hFFFF_FFFF,
                    32'(acs(1) + 2));
        end
        check32("b2b idle cycles", 32'(idle_n), 32'd1);
        check32("b2b cpu_rdata", c_rd[1], pat(1, 5));

        run_random(0, 400);
        run_random(1, 400);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 1: number of BUSY cycles per memory access; legal range 1..4.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports cpu_req, cpu_we  input  1 each  CPU access request (level) and write select.
REQ-005 SHALL have ports cpu_addr, cpu_wdata  input  32 each  CPU byte address and write data.
REQ-006 SHALL have ports cpu_rdata  output  32, cpu_ack  output  1  CPU read data and completion pulse.
REQ-007 SHALL have port cpu_stall  output  1  high while cpu_req is high and cpu_ack is low; gates PC/IR write enables.
REQ-008 SHALL have ports dbg_req, dbg_we  input  1 each, dbg_addr, dbg_wdata  input  32 each  debug/loader requester.
REQ-009 SHALL have ports dbg_rdata  output  32, dbg_ack  output  1  debug read data and completion pulse.
REQ-010 SHALL have ports mem_addr, mem_wdata  output  32 each, mem_read, mem_write  output  1 each  to the shared InstAndDataMemory.
REQ-011 SHALL have port mem_rdata  input  32  memory read data, valid in the same cycle as mem_read.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: if any req is high, SHALL grant one requester, latch its addr, wdata and we, load the cycle counter with ACCESS_CYCLES-1, and go to BUSY; otherwise stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: with both reqs high in IDLE, the grant goes to the requester not granted last; with one req high, that requester wins.
REQ-015 A last-grant pointer SHALL update on every grant; the reset value favours CPU, so CPU wins the first contested grant.
REQ-016 BUSY: SHALL drive mem_addr and mem_wdata from the latched values.
REQ-017 BUSY, read access: SHALL hold mem_read high for every BUSY cycle.
REQ-018 BUSY, write access: SHALL assert mem_write only in the first BUSY cycle.
REQ-019 BUSY: SHALL decrement the counter each cycle, and go to DONE in the cycle the counter equals 0.
REQ-020 On a read, SHALL capture mem_rdata into the granted requester's rdata register in the final BUSY cycle.
REQ-021 On a write, that rdata register SHALL be unchanged.
REQ-022 DONE: SHALL pulse the granted requester's ack high for exactly one cycle, then return to IDLE unconditionally.
REQ-023 DONE: mem_read and mem_write SHALL be low.
REQ-024 Latency: request sampled in IDLE at cycle T; BUSY occupies T+1..T+ACCESS_CYCLES; ack is high at T+ACCESS_CYCLES+1.
REQ-025 cpu_rdata and dbg_rdata SHALL hold their value until the next read completes for that requester.
REQ-026 Requesters hold req until ack and drop it on the edge ending the ack cycle; req still high in the following IDLE is a new request.
REQ-027 Changes to addr, wdata or we while a request is granted SHALL be ignored.
REQ-028 A req dropped before grant SHALL be treated as withdrawn; no access is performed for it.
REQ-029 The non-granted requester's ack SHALL stay low, and its rdata SHALL not change.
REQ-030 cpu_ack and dbg_ack SHALL never be high in the same cycle.
REQ-031 mem_read and mem_write SHALL never be high in the same cycle.
REQ-032 mem_addr and mem_wdata SHALL retain the last latched values in IDLE and DONE.

Reset
REQ-033 With reset high at a clock edge, from any state, the FSM SHALL go to IDLE.
REQ-034 On that reset edge the counter SHALL clear to 0, and the pointer SHALL take its CPU-favoured value.
REQ-035 On that reset edge all outputs SHALL become 0: mem_read, mem_write, acks, both rdata registers, mem_addr, mem_wdata.
REQ-036 A reset during BUSY SHALL abort the access with no ack; a write already issued in the first BUSY cycle is not undone.

Verification
REQ-037 Single CPU read, ACCESS_CYCLES=1: cpu_req=1, cpu_addr=0x10, mem_rdata=0x1234ABCD -> mem_read high one cycle with mem_addr=0x10; cpu_ack two cycles after the sample edge; cpu_rdata=0x1234ABCD; cpu_stall low after ack.
REQ-038 Contention, both reqs high from reset release -> grant order CPU, DBG, CPU, DBG; acks never overlap.
REQ-039 DBG write, ACCESS_CYCLES=3: dbg_we=1, dbg_addr=0x40, dbg_wdata=0xDEADBEEF -> mem_write high in the first BUSY cycle only; dbg_ack on cycle 4; dbg_rdata unchanged.
REQ-040 Address change mid-access: cpu_addr switches 0x10->0x20 during BUSY -> mem_addr stays 0x10.
REQ-041 Reset asserted in the second BUSY cycle (ACCESS_CYCLES=3) -> next cycle IDLE, mem_read=0, no ack, rdata=0.
REQ-042 Back-to-back CPU reads, req held high continuously -> ack every ACCESS_CYCLES+2 cycles with one IDLE cycle between accesses.
